// File: rtl/nibble_wr_arbiter_if.sv
// Producer and FIFO write-side bundle for the nibble write arbiter.
// slave is the arbiter's view, master is the producer/FIFO environment.
interface nibble_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int BW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*BW-1:0] req_byte;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               fifo_in_v;
    logic [BW/2-1:0]    fifo_data_in;
    logic               fifo_in_en;

    modport master (
        output req, req_byte, fifo_in_en,
        input  ack, grant, busy, fifo_in_v, fifo_data_in
    );

    modport slave (
        input  req, req_byte, fifo_in_en,
        output ack, grant, busy, fifo_in_v, fifo_data_in
    );
endinterface

// File: rtl/nibble_wr_arbiter.sv
// Round-robin owner of a nibble FIFO write port: each granted byte goes
// out high nibble then low nibble, never interleaved with another owner.
module nibble_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int BW   = 8
) (
    input logic                clk,
    input logic                rst,
    nibble_wr_arbiter_if.slave bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NW = BW / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HI   = 2'd1;
    localparam logic [1:0] LO   = 2'd2;

    logic [1:0]      state;
    logic [BW-1:0]   byte_q;
    logic [LW-1:0]   last;
    logic [LW-1:0]   win;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;

    logic [NREQ-1:0] eff;
    logic [LW-1:0]   cand;
    logic [LW-1:0]   pick;
    logic            found;

    // The requester being acked this cycle sits out one arbitration
    always_comb begin
        eff   = bus.req & ~ack_q;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last) + k) % NREQ);
            if (!found && eff[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            byte_q  <= '0;
            last    <= LW'(NREQ - 1);
            win     <= '0;
            grant_q <= '0;
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        byte_q  <= bus.req_byte[pick*BW +: BW];
                        win     <= pick;
                        grant_q <= NREQ'(1) << pick;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (bus.fifo_in_en)
                        state <= LO;
                end
                LO: begin
                    if (bus.fifo_in_en) begin
                        state   <= IDLE;
                        last    <= win;
                        ack_q   <= grant_q;
                        grant_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = (state == HI) || (state == LO);
    assign bus.fifo_in_v = (state == HI) || (state == LO);

    always_comb begin
        bus.fifo_data_in = '0;
        unique case (1'b1)
            state == HI: bus.fifo_data_in = byte_q[BW-1:NW];
            state == LO: bus.fifo_data_in = byte_q[NW-1:0];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nibble_wr_arbiter.sv
// Directed bench for nibble_wr_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_nibble_wr_arbiter;
    localparam int NREQ = 4;
    localparam int BW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    nibble_wr_arbiter_if #(.NREQ(NREQ), .BW(BW)) bus ();

    nibble_wr_arbiter #(.NREQ(NREQ), .BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [3:0] g,
                           input logic [3:0] a, input logic b,
                           input logic v, input logic [3:0] d);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".ack"}, 32'(bus.ack), 32'(a));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
        check({tag, ".v"}, 32'(bus.fifo_in_v), 32'(v));
        check({tag, ".data"}, 32'(bus.fifo_data_in), 32'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        bus.req_byte[i*BW +: BW] = b;
    endtask

    task automatic do_reset;
        bus.req        = '0;
        bus.req_byte   = '0;
        bus.fifo_in_en = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic       g1;
        logic [3:0] oh;
        logic [3:0] nib;
        int         k;
        int         ph;

        // single byte, minimum latency
        do_reset;
        exp_out("rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0001;
        set_byte(0, 8'hA5);
        tick; exp_out("t1c1", 4'b0001, 4'b0000, 1'b1, 1'b1, 4'hA);
        tick; exp_out("t1c2", 4'b0001, 4'b0000, 1'b1, 1'b1, 4'h5);
        tick; exp_out("t1c3", 4'b0000, 4'b0001, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0000;

        // two simultaneous requesters
        do_reset;
        g1 = 1'b0;
        bus.req = 4'b0101;
        set_byte(0, 8'h3C);
        set_byte(1, 8'hFF);
        set_byte(2, 8'h96);
        tick; g1 |= bus.grant[1];
        exp_out("t2c1", 4'b0001, 4'b0000, 1'b1, 1'b1, 4'h3);
        tick; g1 |= bus.grant[1];
        exp_out("t2c2", 4'b0001, 4'b0000, 1'b1, 1'b1, 4'hC);
        tick; g1 |= bus.grant[1];
        exp_out("t2c3", 4'b0000, 4'b0001, 1'b0, 1'b0, 4'h0);
        bus.req[0] = 1'b0;
        tick; g1 |= bus.grant[1];
        exp_out("t2c4", 4'b0100, 4'b0000, 1'b1, 1'b1, 4'h9);
        tick; g1 |= bus.grant[1];
        exp_out("t2c5", 4'b0100, 4'b0000, 1'b1, 1'b1, 4'h6);
        tick; g1 |= bus.grant[1];
        exp_out("t2c6", 4'b0000, 4'b0100, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0000;
        check("t2_no_grant1", 32'(g1), 32'(1'b0));

        // all four held: rotation 0,1,2,3,0,1 with one byte per 3 cycles
        do_reset;
        set_byte(0, 8'h11);
        set_byte(1, 8'h22);
        set_byte(2, 8'h33);
        set_byte(3, 8'h44);
        bus.req = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            tick;
            k   = (c - 1) / 3;
            ph  = (c - 1) % 3;
            oh  = 4'b0001 << (k % 4);
            nib = 4'(k % 4 + 1);
            if (ph == 2)
                exp_out($sformatf("t3c%0d", c), 4'b0000, oh,
                        1'b0, 1'b0, 4'h0);
            else
                exp_out($sformatf("t3c%0d", c), oh, 4'b0000,
                        1'b1, 1'b1, nib);
        end
        bus.req = 4'b0000;

        // stalls in HI and LO, byte change ignored
        do_reset;
        bus.req = 4'b0010;
        set_byte(1, 8'h7E);
        tick; exp_out("t4hi", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'h7);
        bus.fifo_in_en = 1'b0;
        set_byte(1, 8'hFF);
        repeat (5) begin
            tick; exp_out("t4shi", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'h7);
        end
        bus.fifo_in_en = 1'b1;
        tick; exp_out("t4lo", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'hE);
        bus.fifo_in_en = 1'b0;
        set_byte(1, 8'h00);
        repeat (3) begin
            tick; exp_out("t4slo", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'hE);
        end
        bus.fifo_in_en = 1'b1;
        tick; exp_out("t4ack", 4'b0000, 4'b0010, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0000;
        tick; exp_out("t4idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);

        // asynchronous reset while in LO
        do_reset;
        bus.req = 4'b0001;
        set_byte(0, 8'hA5);
        tick;
        tick; exp_out("t5lo", 4'b0001, 4'b0000, 1'b1, 1'b1, 4'h5);
        #2 rst = 1'b0;
        #1 exp_out("t5rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0010;
        set_byte(1, 8'h5A);
        tick; exp_out("t5hold", 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
        #2 rst = 1'b1;
        tick; exp_out("t5g1", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'h5);
        tick; exp_out("t5lo1", 4'b0010, 4'b0000, 1'b1, 1'b1, 4'hA);
        tick; exp_out("t5ack", 4'b0000, 4'b0010, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/nibble_wr_arbiter.md
Name: nibble_wr_arbiter

Overview:
- Shares the 4-bit write port of the nibble-in / byte-out FIFO between NREQ byte producers.
- Each granted producer's byte is latched, then written as two consecutive nibbles: high nibble first, low nibble second.
- No other requester's nibble can land between the two halves, so every FIFO byte read back is one producer's original byte.
- Sits between the producer blocks and the FIFO write side: in_v / in_en / data_in.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BW, 8, requester byte width; must equal 2 x FIFO nibble width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held high until ack.
- req_byte  in  NREQ*BW  requester i's byte in bits [i*BW+BW-1 : i*BW]; sampled only at grant.
- ack  out  NREQ  one-hot, one-cycle pulse: requester's byte fully written.
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- busy  out  1  high in HI or LO.
- fifo_in_v  out  1  nibble valid toward FIFO.
- fifo_data_in  out  BW/2  nibble toward FIFO.
- fifo_in_en  in  1  FIFO can accept a nibble this cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst low forces immediately, independent of clk:
  - state=IDLE, grant=0, ack=0, busy=0, fifo_in_v=0, fifo_data_in=0.
  - latched byte=0, round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, HI, LO. All outputs are decoded from registered state / registers; no combinational path from req to fifo_in_v.
- IDLE:
  - Effective request vector = req with the requester acked this cycle masked out.
  - If nonzero: winner = first set bit scanning last+1, last+2, ... modulo NREQ.
  - On the edge: latch winner's byte, set grant one-hot, go to HI.
  - Else stay in IDLE.
- HI:
  - fifo_in_v=1, fifo_data_in = latched[BW-1:BW/2].
  - On an edge with fifo_in_en=1, go to LO. Otherwise hold, with data stable.
- LO:
  - fifo_in_v=1, fifo_data_in = latched[BW/2-1:0].
  - On an edge with fifo_in_en=1: go to IDLE, last <- winner index, ack[winner]=1 for the next cycle only, grant <- 0.
  - Otherwise hold.
- Latency and throughput:
  - req high in cycle 0 with fifo_in_en=1 throughout: HI in cycle 1, LO in cycle 2, ack in cycle 3.
  - Steady-state throughput is 1 byte per 3 cycles; the IDLE bubble is intentional.
- Request handling:
  - req_byte changes after grant are ignored.
  - Dropping req during HI/LO does not abort; the byte is still written and acked.
  - The acked requester may keep req high in the ack cycle without being re-granted that cycle. It is eligible again from the next IDLE.
- Stalls: fifo_in_en low for any number of cycles stalls HI or LO indefinitely, with fifo_in_v and fifo_data_in held. There is no timeout.
- Priority and fairness: simultaneous requests are resolved only by round-robin. No requester waits more than NREQ-1 grants.
- Reset mid-transfer:
  - A partially written byte (HI accepted, LO not yet accepted) is dropped without ack.
  - The FIFO must be reset with the same rst to stay nibble-aligned.

Test Plan:
- Reset, then req=0001, byte0=0xA5, fifo_in_en=1 -> cycle 1: fifo_data_in=0xA, grant=0001; cycle 2: 0x5; cycle 3: ack=0001, grant=0, busy=0.
- req=0101, byte0=0x3C, byte2=0x96 simultaneously -> nibble stream 3,C,9,6; ack[0] before ack[2]; requester 1 never granted.
- req=1111 held continuously, bytes 0x11/0x22/0x33/0x44 -> grant order 0,1,2,3,0,1; one ack every 3 cycles; stream 1,1,2,2,3,3,4,4,1,1.
- Grant requester 1 with byte 0x7E, hold fifo_in_en=0 for 5 cycles during HI, then 3 cycles during LO -> fifo_data_in stays 0x7 then 0xE while stalled; ack arrives exactly one cycle after LO acceptance; byte change during stall has no effect.
- Assert rst=0 asynchronously mid-cycle while in LO -> all outputs 0 before the next edge, no ack. After release with req=0010, requester 1 is granted, since pointer is reset and requester 0 is idle.
